// File: rtl/kmap_preimage_scan.sv
// Streams every minterm of a latched 4-input truth table whose cell class matches a target,
// lowest index first, over a valid/ready handshake.
module kmap_preimage_scan #(
  parameter int NV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2**NV-1:0]  table_care,
  input  logic [2**NV-1:0]  table_val,
  input  logic [1:0]        target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NV-1:0]     out_abcd,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [NV:0]       count
);

  localparam int DEPTH = 2**NV;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_next;
  logic [DEPTH-1:0] mask, mask_next, sel_mask;
  logic [NV-1:0]    low_next;
  logic             onehot_next;
  logic             fire;

  always_comb begin
    sel_mask = '0;
    case (target)
      2'b00:   sel_mask = table_care & ~table_val;
      2'b01:   sel_mask = table_care & table_val;
      2'b10:   sel_mask = ~table_care;
      default: sel_mask = table_care;
    endcase
  end

  assign fire = (state == SCAN) && out_valid && out_ready;

  // Outputs are registered, so decode them from the mask the next cycle will hold.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    case (state)
      IDLE: begin
        if (start) begin
          mask_next  = sel_mask;
          state_next = SCAN;
        end
      end
      default: begin
        if (mask == '0)
          state_next = IDLE;
        else if (fire)
          mask_next = mask & (mask - DEPTH'(1));
      end
    endcase
  end

  always_comb begin
    low_next = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (mask_next[i])
        low_next = NV'(i);
    onehot_next = (mask_next != '0) && ((mask_next & (mask_next - DEPTH'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_abcd  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      mask      <= mask_next;
      busy      <= (state_next == SCAN);
      out_valid <= (state_next == SCAN) && (mask_next != '0);
      out_abcd  <= ((state_next == SCAN) && (mask_next != '0)) ? low_next : '0;
      out_last  <= (state_next == SCAN) && onehot_next;
      done      <= (state_next == SCAN) && (mask_next == '0);
      if (state == IDLE && start)
        count <= '0;
      else if (fire)
        count <= count + (NV+1)'(1);
    end
  end

endmodule
